// File: rtl/cm_arb_rr_lock.sv
// AHB-Lite slave-port arbiter: priority + round-robin tie-break, locked-transfer
// ownership with timeout and a one-arbitration penalty for the timed-out owner.
module cm_arb_rr_lock #(
    parameter int unsigned REQ_NUM   = 4,
    parameter int unsigned PRI_WIDTH = 2,
    parameter int unsigned RR_EN     = 1,
    parameter int unsigned MAX_LOCK  = 16,
    localparam int unsigned IDX_W    = (REQ_NUM > 2) ? $clog2(REQ_NUM) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [REQ_NUM-1:0]             req,
    input  logic [PRI_WIDTH*REQ_NUM-1:0]   pri,
    input  logic [REQ_NUM-1:0]             lock,
    input  logic                           ready,
    output logic [REQ_NUM-1:0]             gnt,
    output logic [IDX_W-1:0]               gnt_idx,
    output logic [REQ_NUM-1:0]             last_gnt,
    output logic                           locked
);

    localparam int unsigned CNT_W = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_owner;
    logic [CNT_W-1:0]     r_lock_cnt;
    logic [REQ_NUM-1:0]   r_pen_mask;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [REQ_NUM-1:0]   r_last_gnt;

    logic [REQ_NUM-1:0]   w_eff_req;
    logic [PRI_WIDTH-1:0] w_top;
    logic [REQ_NUM-1:0]   w_cand;
    logic                 w_arb_found;
    logic [IDX_W-1:0]     w_arb_idx;
    logic                 w_hold;
    logic                 w_timeout;
    logic [IDX_W-1:0]     w_sel_idx;
    logic                 w_gnt_en;
    logic [REQ_NUM-1:0]   w_gnt;

    state_t               w_state_nxt;
    logic [IDX_W-1:0]     w_owner_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [REQ_NUM-1:0]   w_pen_nxt;

    // Priority arbitration over requests, skipping a penalised master unless it is alone
    always_comb begin
        w_eff_req = req & ~r_pen_mask;
        if (w_eff_req == '0) begin
            w_eff_req = req;
        end

        w_top = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            if (w_eff_req[i] && (pri[i*PRI_WIDTH +: PRI_WIDTH] > w_top)) begin
                w_top = pri[i*PRI_WIDTH +: PRI_WIDTH];
            end
        end

        w_cand = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            w_cand[i] = w_eff_req[i] && (pri[i*PRI_WIDTH +: PRI_WIDTH] == w_top);
        end

        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        if (RR_EN != 0) begin
            for (int unsigned k = 1; k <= REQ_NUM; k++) begin
                if (!w_arb_found && w_cand[IDX_W'((32'(r_rr_ptr) + k) % REQ_NUM)]) begin
                    w_arb_found = 1'b1;
                    w_arb_idx   = IDX_W'((32'(r_rr_ptr) + k) % REQ_NUM);
                end
            end
        end else begin
            for (int unsigned i = 0; i < REQ_NUM; i++) begin
                if (!w_arb_found && w_cand[i]) begin
                    w_arb_found = 1'b1;
                    w_arb_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Lock owner bypasses arbitration while it keeps requesting
    always_comb begin
        w_hold    = (r_state == ST_LOCK) && req[r_owner];
        w_timeout = (MAX_LOCK != 0) && ((32'(r_lock_cnt) + 32'd1) == MAX_LOCK);
        w_sel_idx = w_hold ? r_owner : w_arb_idx;
        w_gnt_en  = (w_hold || w_arb_found) && ready && rst_n;
        w_gnt     = '0;
        if (w_gnt_en) begin
            w_gnt[w_sel_idx] = 1'b1;
        end
    end

    // Next-state logic; only evaluated into registers on ready cycles
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_lock_cnt;
        w_pen_nxt   = r_pen_mask;
        if (w_hold) begin
            w_pen_nxt = '0;
            if (!lock[r_owner]) begin
                w_state_nxt = ST_ARB;
                w_cnt_nxt   = '0;
            end else if (w_timeout) begin
                w_state_nxt          = ST_ARB;
                w_cnt_nxt            = '0;
                w_pen_nxt[r_owner]   = 1'b1;
            end else if (r_lock_cnt != CNT_MAX) begin
                w_cnt_nxt = r_lock_cnt + CNT_W'(1);
            end
        end else begin
            w_state_nxt = ST_ARB;
            w_cnt_nxt   = '0;
            if (w_arb_found) begin
                w_pen_nxt = '0;
                if (lock[w_arb_idx]) begin
                    if (MAX_LOCK == 1) begin
                        w_pen_nxt[w_arb_idx] = 1'b1;
                    end else begin
                        w_state_nxt = ST_LOCK;
                        w_owner_nxt = w_arb_idx;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ARB;
            r_owner    <= '0;
            r_lock_cnt <= '0;
            r_pen_mask <= '0;
            r_rr_ptr   <= IDX_W'(REQ_NUM - 1);
            r_last_gnt <= '0;
        end else if (ready) begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_cnt_nxt;
            r_pen_mask <= w_pen_nxt;
            if (w_gnt != '0) begin
                r_rr_ptr <= w_sel_idx;
                if (w_gnt != r_last_gnt) begin
                    r_last_gnt <= w_gnt;
                end
            end
        end
    end

    assign gnt      = w_gnt;
    assign gnt_idx  = w_gnt_en ? w_sel_idx : '0;
    assign last_gnt = r_last_gnt;
    assign locked   = (r_state == ST_LOCK);

endmodule

// File: doc/cm_arb_rr_lock.md
Name: cm_arb_rr_lock

Overview:
- Next-generation AHB-Lite matrix slave-port arbiter, successor to the fixed-priority, ready-gated arbiter.
- Selects among REQ_NUM masters using a per-request priority field.
- Adds round-robin tie-breaking within the highest active priority level, and locked-transfer ownership for HMASTLOCK sequences.
- Adds a lock timeout counter with a one-arbitration penalty to prevent starvation. Output grant is one-hot plus an encoded index.

Parameters:
- REQ_NUM, 4, number of requesters (>=2).
- PRI_WIDTH, 2, priority field width per requester; larger value wins.
- RR_EN, 1, 1 = round-robin among equal top priority; 0 = lowest index wins.
- MAX_LOCK, 16, max granted ready-cycles per lock tenure; 0 = no timeout.
- IDX_W (localparam), max(1,$clog2(REQ_NUM)), index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  REQ_NUM  request per master.
- pri  in  PRI_WIDTH*REQ_NUM  priority of master i in bits [i*PRI_WIDTH +: PRI_WIDTH].
- lock  in  REQ_NUM  master i requests locked tenure (HMASTLOCK).
- ready  in  1  slave-side HREADY; arbitration advances only when 1.
- gnt  out  REQ_NUM  one-hot grant, combinational.
- gnt_idx  out  IDX_W  encoded index of gnt; 0 when gnt==0.
- last_gnt  out  REQ_NUM  registered copy of last nonzero gnt.
- locked  out  1  state==LOCK.

Behaviour:
- Reset: state=ARB, owner=0, lock_cnt=0, pen_mask=0, rr_ptr=REQ_NUM-1 (index 0 favoured first), last_gnt=0, locked=0. gnt=0 and gnt_idx=0 whenever rst_n=0.
- gnt=0 whenever ready=0. No state updates when ready=0.
- Arbitration function (combinational):
  - eff_req = req & ~pen_mask if that is nonzero, else req.
  - top = max pri over eff_req; cand = eff_req bits whose pri==top.
  - RR_EN=1: winner = first cand index scanning rr_ptr+1, rr_ptr+2, ... modulo REQ_NUM.
  - RR_EN=0: winner = lowest cand index.
  - No cand: gnt=0.
- ARB state:
  - gnt=onehot(winner).
  - On ready & gnt!=0 & lock[winner]: ->LOCK, owner=winner, lock_cnt=1.
  - If MAX_LOCK==1, immediate timeout applies instead (stay ARB, pen_mask=onehot(winner)).
- LOCK state:
  - If req[owner]=1: gnt=onehot(owner), bypassing priority.
  - On ready:
    - lock[owner]=0: final beat granted, ->ARB, lock_cnt=0.
    - Else lock_cnt+1==MAX_LOCK (MAX_LOCK!=0): ->ARB, pen_mask=onehot(owner), lock_cnt=0.
    - Else lock_cnt++ (saturating counter, width clog2(MAX_LOCK+1)).
  - If req[owner]=0: ownership dropped. gnt = normal arbitration result the same cycle; state follows ARB rules for that result (may re-enter LOCK with new owner).
- pen_mask: cleared on the first ready cycle with gnt!=0 after it is set, except when being set that same cycle.
- rr_ptr <= gnt_idx on every ready cycle with gnt!=0, including lock beats.
- last_gnt <= gnt on ready & gnt!=0 & gnt!=last_gnt.
- Simultaneous events:
  - Timeout and lock deassert in the same cycle: treat as normal release; no penalty.
  - Penalised master the only requester: still granted (eff_req fallback).
- Reset asserted mid-LOCK: immediate return to reset values; gnt drops asynchronously.

Test Plan:
- Fixed priority: REQ_NUM=4, req=4'b1111, pri={2'd0,2'd3,2'd1,2'd3} (m3..m0), ready=1, RR_EN=0 -> gnt=4'b0001 every cycle, gnt_idx=0.
- Round-robin tie: same stimulus, RR_EN=1, 4 ready cycles -> gnt sequence 0001, 0100, 0001, 0100; m1/m3 never granted; last_gnt tracks with 1-cycle lag.
- ready stall: ready=0 for 3 cycles mid-sequence -> gnt=0, rr_ptr and last_gnt frozen; sequence resumes unchanged when ready=1.
- Lock hold: m1 wins with lock[1]=1 for 3 cycles while m0 (higher pri) requests -> gnt=0010 for 3 ready cycles, locked=1; lock[1]=0 on 3rd beat -> next cycle m0 granted, locked=0.
- Lock timeout: MAX_LOCK=4, m2 holds lock indefinitely, m0 requesting -> m2 granted 4 ready cycles, then m0 granted once (pen_mask=0100), then normal arbitration resumes.
- Reset mid-LOCK: assert rst_n=0 during locked tenure -> gnt=0 immediately, last_gnt=0, locked=0; after release with req=4'b0001, gnt=0001 first cycle.
